// File: rtl/nibble_mult_seq_if.sv
// Bus between the step-driven multiplier and its requester.
// Handshake: start is a request that is taken only on a cycle where the
// sequencer is idle (busy=0 and no done pulse); a/b are captured on that
// same edge, and done marks the single cycle in which product is final.
interface nibble_mult_seq_if #(
  parameter int N = 8
);
  logic [1:0]     count_in;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic           err;
  logic [2*N-1:0] product;

  modport master (
    output count_in, start, a, b,
    input  busy, done, err, product
  );

  modport slave (
    input  count_in, start, a, b,
    output busy, done, err, product
  );
endinterface

// File: rtl/nibble_mult_seq.sv
// Sequential NxN multiplier: one nibble-pair partial product per upstream
// counter step, accumulated into a 2N-bit product over a full 0..3 pass.
module nibble_mult_seq #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                aclr_n,
  nibble_mult_seq_if.slave    bus,
  output logic [1:0]          dbg_state
);
  localparam int H = N / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   ra_q, ra_d;
  logic [N-1:0]   rb_q, rb_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [1:0]     exp_q, exp_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [H-1:0]   pa, pb;
  logic [N-1:0]   pp;
  logic [2*N-1:0] pp_shifted;

  // Nibble selection and weighting for the current step.
  always_comb begin
    pa         = ra_q[H-1:0];
    pb         = rb_q[H-1:0];
    case (bus.count_in)
      2'd0: begin pa = ra_q[H-1:0]; pb = rb_q[H-1:0]; end
      2'd1: begin pa = ra_q[H-1:0]; pb = rb_q[N-1:H]; end
      2'd2: begin pa = ra_q[N-1:H]; pb = rb_q[H-1:0]; end
      default: begin pa = ra_q[N-1:H]; pb = rb_q[N-1:H]; end
    endcase
    pp = {{H{1'b0}}, pa} * {{H{1'b0}}, pb};
    case (bus.count_in)
      2'd0:    pp_shifted = {{N{1'b0}}, pp};
      2'd3:    pp_shifted = {pp, {N{1'b0}}};
      default: pp_shifted = {{H{1'b0}}, pp, {H{1'b0}}};
    endcase
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    prod_d  = prod_q;
    exp_d   = exp_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        exp_d = 2'd0;
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          prod_d  = '0;
          state_d = (bus.count_in == 2'd3) ? S_CALC : S_WAIT;
        end
      end
      S_WAIT: begin
        exp_d = 2'd0;
        if (bus.count_in == 2'd3) state_d = S_CALC;
      end
      S_CALC: begin
        // A step that does not follow the expected sequence means the
        // counter was disturbed; the partial result is meaningless.
        if (bus.count_in == exp_q) begin
          prod_d = prod_q + pp_shifted;
          exp_d  = exp_q + 2'd1;
          if (bus.count_in == 2'd3) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      prod_q  <= '0;
      exp_q   <= 2'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      prod_q  <= prod_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy    = (state_q == S_WAIT) || (state_q == S_CALC);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.product = prod_q;
  assign dbg_state   = state_q;
endmodule
